// File: rtl/xbar_input_queue.sv
// Per-input-port packet queue of the crossbar switch.
// Buffers {destination, payload} words from the source over valid/ready and
// releases one word onto a registered output whenever the current slot
// (slot_tick + slot_sel) is owned by this input port.
module xbar_input_queue #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int PORTS   = 4,
  parameter int PORT_ID = 0,
  parameter int SEL_W   = $clog2(PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [SEL_W-1:0]           in_dest,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       slot_tick,
  input  logic [SEL_W-1:0]           slot_sel,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_dest,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int WORD_W = DATA_W + SEL_W;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [SEL_W-1:0] MY_SEL   = SEL_W'(PORT_ID);

  // Reject parameter sets the pointer arithmetic and port matching cannot honour.
  generate
    if (PORT_ID < 0 || PORT_ID >= PORTS) begin : g_bad_port_id
      $error("xbar_input_queue: PORT_ID must satisfy 0 <= PORT_ID < PORTS");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("xbar_input_queue: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  // Storage: written on push, read only through the registered output stage.
  logic [WORD_W-1:0] mem_reg [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic              overflow_reg, overflow_next;
  logic              out_valid_reg;
  logic [WORD_W-1:0] out_word_reg;

  logic full;
  logic push;
  logic pop;

  // Full queue refuses new words even when a pop happens in the same cycle.
  assign full     = (level_reg == FULL_LVL);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  // Pop uses the occupancy before this cycle's push, so a word just being
  // written cannot be popped on the same edge. An out-of-range slot_sel
  // can never equal MY_SEL because PORT_ID < PORTS.
  assign pop      = slot_tick && (slot_sel == MY_SEL) && (level_reg != '0);

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase

    // The word offered while full is dropped; only the flag records it.
    if (in_valid && full) begin
      overflow_next = 1'b1;
    end
  end

  // Array write port; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= {in_dest, in_data};
    end
  end

  // Control state and registered output stage (zeroed when not valid).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
      out_valid_reg <= pop;
      out_word_reg  <= pop ? mem_reg[rd_ptr_reg] : '0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_dest  = out_word_reg[WORD_W-1:DATA_W];
  assign out_data  = out_word_reg[DATA_W-1:0];
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_xbar_input_queue.sv
// Scoreboard bench for xbar_input_queue: the stimulus pushes the expected
// {dest,data} of every pop it causes; a negedge monitor checks every word
// the DUT presents against that queue.
module tb_xbar_input_queue;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int PORTS   = 4;
  localparam int PORT_ID = 2;
  localparam int SEL_W   = 2;
  localparam int LVL_W   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic [SEL_W-1:0]  in_dest = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              slot_tick = 1'b0;
  logic [SEL_W-1:0]  slot_sel = '0;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_dest;
  logic              out_valid;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [SEL_W+DATA_W-1:0] exp_q [$];

  xbar_input_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PORTS  (PORTS),
    .PORT_ID(PORT_ID)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .slot_tick(slot_tick),
    .slot_sel (slot_sel),
    .out_data (out_data),
    .out_dest (out_dest),
    .out_valid(out_valid),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // One cycle of stimulus: apply inputs, let the edge sample them, return to idle.
  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dst,
                       input logic t, input logic [1:0] s);
    in_valid  = v;
    in_data   = d;
    in_dest   = dst;
    slot_tick = t;
    slot_sel  = s;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    slot_tick = 1'b0;
    slot_sel  = '0;
  endtask

  task automatic expect_pop(input logic [1:0] dst, input logic [7:0] d);
    exp_q.push_back({dst, d});
  endtask

  // Monitor: every presented word must be the oldest expected one.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL pop_unexpected: got dest=%0d data=0x%0h required no output",
                 out_dest, out_data);
      end else begin
        logic [SEL_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_dest, out_data} !== e) begin
          mismatched++;
          $display("FAIL pop_word: got dest=%0d data=0x%0h required dest=%0d data=0x%0h",
                   out_dest, out_data, e[9:8], e[7:0]);
        end else begin
          $display("ok   pop_word: dest=%0d data=0x%0h", out_dest, out_data);
        end
      end
    end else if (out_valid !== 1'b0 || out_data !== '0 || out_dest !== '0) begin
      compared++;
      mismatched++;
      $display("FAIL idle_output: got valid=%b dest=%0d data=0x%0h required 0/0/0",
               out_valid, out_dest, out_data);
    end
  end

  initial begin
    // T1: reset held two cycles, source offering meanwhile.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_ready_in_rst", int'(in_ready), 0);
    chk("t1_level_rst", int'(level), 0);
    chk("t1_valid_rst", int'(out_valid), 0);
    chk("t1_overflow_rst", int'(overflow), 0);
    in_valid = 1'b0;
    in_data  = '0;
    rst      = 1'b0;
    #1;
    chk("t1_ready_after", int'(in_ready), 1);

    // T2: three pushes, then a matching slot pops the oldest.
    drive(1'b1, 8'hA1, 2'd1, 1'b0, 2'd0);
    drive(1'b1, 8'hB2, 2'd2, 1'b0, 2'd0);
    drive(1'b1, 8'hC3, 2'd3, 1'b0, 2'd0);
    chk("t2_level3", int'(level), 3);
    expect_pop(2'd1, 8'hA1);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    chk("t2_valid", int'(out_valid), 1);
    chk("t2_level2", int'(level), 2);

    // T3: slot owned by another port.
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID + 1));
    chk("t3_no_valid", int'(out_valid), 0);
    chk("t3_level2", int'(level), 2);
    expect_pop(2'd2, 8'hB2);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    expect_pop(2'd3, 8'hC3);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    chk("t3_drained", int'(level), 0);

    // T4: fill, overflow attempt, full drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(8'h10 + i), 2'(i), 1'b0, 2'd0);
    end
    chk("t4_level_full", int'(level), 16);
    chk("t4_ready_full", int'(in_ready), 0);
    drive(1'b1, 8'h55, 2'd0, 1'b0, 2'd0);
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_level_still_full", int'(level), 16);
    for (int i = 0; i < DEPTH; i++) begin
      expect_pop(2'(i), 8'(8'h10 + i));
      drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    end
    chk("t4_level_empty", int'(level), 0);
    chk("t4_overflow_sticky", int'(overflow), 1);

    // T5: push and pop on the same edge at level 5.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h20 + i), 2'(i), 1'b0, 2'd0);
    end
    expect_pop(2'd0, 8'h20);
    drive(1'b1, 8'h99, 2'd1, 1'b1, 2'(PORT_ID));
    chk("t5_level_same", int'(level), 5);
    for (int i = 1; i < 5; i++) begin
      expect_pop(2'(i), 8'(8'h20 + i));
      drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    end
    expect_pop(2'd1, 8'h99);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    chk("t5_level_empty", int'(level), 0);

    // T6: matching slot on an empty queue while a word arrives.
    drive(1'b1, 8'h77, 2'd3, 1'b1, 2'(PORT_ID));
    chk("t6_no_valid", int'(out_valid), 0);
    chk("t6_level1", int'(level), 1);
    expect_pop(2'd3, 8'h77);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    chk("t6_level0", int'(level), 0);

    // T7: reset in the middle of a drain at level 7.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(8'h40 + i), 2'(i), 1'b0, 2'd0);
    end
    expect_pop(2'd0, 8'h40);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    expect_pop(2'd1, 8'h41);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    chk("t7_level7", int'(level), 7);
    rst = 1'b1;
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    chk("t7_level_rst", int'(level), 0);
    chk("t7_valid_rst", int'(out_valid), 0);
    chk("t7_overflow_rst", int'(overflow), 0);
    rst = 1'b0;
    #1;

    // Pointers restart cleanly after reset.
    drive(1'b1, 8'h3C, 2'd2, 1'b0, 2'd0);
    expect_pop(2'd2, 8'h3C);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 2'(PORT_ID));
    chk("t7_level_post", int'(level), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
